// File: rtl/pong_game_engine_if.sv
// Game-engine bus: frame pulse and paddle positions in, ball position, scores and status out.
interface pong_game_engine_if #(
    parameter int unsigned HEIGHT_COUNTER_SIZE = 9,
    parameter int unsigned WIDTH_COUNTER_SIZE  = 10
);
    logic                          frame_tick;
    logic [HEIGHT_COUNTER_SIZE:0]  paddle_1_pos;
    logic [HEIGHT_COUNTER_SIZE:0]  paddle_2_pos;
    logic [WIDTH_COUNTER_SIZE:0]   ball_pos_x;
    logic [HEIGHT_COUNTER_SIZE:0]  ball_pos_y;
    logic [3:0]                    score_1;
    logic [3:0]                    score_2;
    logic                          point_scored;
    logic                          game_over;

    // Frame source / paddle controllers / graphics side
    modport master (
        output frame_tick,
        output paddle_1_pos,
        output paddle_2_pos,
        input  ball_pos_x,
        input  ball_pos_y,
        input  score_1,
        input  score_2,
        input  point_scored,
        input  game_over
    );

    // Game engine side
    modport slave (
        input  frame_tick,
        input  paddle_1_pos,
        input  paddle_2_pos,
        output ball_pos_x,
        output ball_pos_y,
        output score_1,
        output score_2,
        output point_scored,
        output game_over
    );
endinterface

// File: rtl/pong_game_engine.sv
// Pong game engine: advances the ball once per frame, bounces it off walls and
// paddles, detects misses, keeps scores and runs the serve delay between points.
// Optional feature macro: SPEEDUP_EN (ball speed grows on every paddle hit,
// saturating at twice the base speed, and is restored on each serve).
module pong_game_engine #(
    parameter int unsigned HEIGHT_COUNTER_SIZE = 9,
    parameter int unsigned WIDTH_COUNTER_SIZE  = 10,
    parameter int unsigned SCREEN_WIDTH        = 640,
    parameter int unsigned SCREEN_HEIGHT       = 480,
    parameter int unsigned PADDLE_1_X          = 16,
    parameter int unsigned PADDLE_2_X          = 616,
    parameter int unsigned PADDLE_WIDTH        = 8,
    parameter int unsigned PADDLE_HEIGHT       = 64,
    parameter int unsigned BALL_SIDE_SIZE      = 8,
    parameter int unsigned INITIAL_BALL_X      = 316,
    parameter int unsigned INITIAL_BALL_Y      = 236,
    parameter int unsigned BALL_SPEED          = 2,
    parameter int unsigned SERVE_DELAY_FRAMES  = 60,
    parameter int unsigned WIN_SCORE           = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    pong_game_engine_if.slave    bus
);

    // Port widths and one-bit-wider arithmetic widths
    localparam int unsigned XW  = WIDTH_COUNTER_SIZE + 1;
    localparam int unsigned XE  = XW + 1;
    localparam int unsigned YW  = HEIGHT_COUNTER_SIZE + 1;
    localparam int unsigned YE  = YW + 1;
    localparam int unsigned SPW = $clog2(2 * BALL_SPEED + 1);
    localparam int unsigned CW  = $clog2(SERVE_DELAY_FRAMES + 1);
    localparam int unsigned SCW = 4;

    // Geometry constants
    localparam logic [XE-1:0]  FACE_LEFT   = XE'(PADDLE_1_X + PADDLE_WIDTH);
    localparam logic [XE-1:0]  FACE_RIGHT  = XE'(PADDLE_2_X - BALL_SIDE_SIZE);
    localparam logic [XE-1:0]  X_MAX       = XE'(SCREEN_WIDTH - BALL_SIDE_SIZE);
    localparam logic [YE-1:0]  Y_MAX       = YE'(SCREEN_HEIGHT - BALL_SIDE_SIZE);
    localparam logic [YE-1:0]  BALL_SIDE_Y = YE'(BALL_SIDE_SIZE);
    localparam logic [YE-1:0]  PADDLE_H_Y  = YE'(PADDLE_HEIGHT);
    localparam logic [XW-1:0]  SERVE_X     = XW'(INITIAL_BALL_X);
    localparam logic [YW-1:0]  SERVE_Y     = YW'(INITIAL_BALL_Y);
    localparam logic [CW-1:0]  SERVE_LAST  = CW'(SERVE_DELAY_FRAMES);
    localparam logic [SCW-1:0] SCORE_WIN   = SCW'(WIN_SCORE);
    localparam logic [SPW-1:0] SPEED_INIT  = SPW'(BALL_SPEED);

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    state_t           state;
    logic [XW-1:0]    ball_x;
    logic [YW-1:0]    ball_y;
    logic             dx_right;
    logic             dy_down;
    logic [CW-1:0]    serve_cnt;
    logic [SCW-1:0]   score_1;
    logic [SCW-1:0]   score_2;
    logic             point_scored;
    logic             game_over;
    logic [SPW-1:0]   speed;

    logic [XE-1:0]    x_e;
    logic [XE-1:0]    speed_x;
    logic [XE-1:0]    x_step;
    logic [YE-1:0]    y_e;
    logic [YE-1:0]    speed_y;
    logic [YE-1:0]    pad_1_e;
    logic [YE-1:0]    pad_2_e;
    logic [YE-1:0]    y_next;
    logic             dy_next;
    logic             overlap_1;
    logic             overlap_2;
    logic             hit_left;
    logic             hit_right;
    logic             miss_left;
    logic             miss_right;
    logic [CW-1:0]    serve_cnt_inc;
    logic [SCW-1:0]   score_1_inc;
    logic [SCW-1:0]   score_2_inc;

    assign x_e           = XE'(ball_x);
    assign y_e           = YE'(ball_y);
    assign speed_x       = XE'(speed);
    assign speed_y       = YE'(speed);
    assign pad_1_e       = YE'(bus.paddle_1_pos);
    assign pad_2_e       = YE'(bus.paddle_2_pos);
    assign serve_cnt_inc = CW'(serve_cnt + CW'(1));
    assign score_1_inc   = SCW'(score_1 + SCW'(1));
    assign score_2_inc   = SCW'(score_2 + SCW'(1));

`ifdef SPEEDUP_EN
    localparam logic [SPW-1:0] SPEED_MAX = SPW'(2 * BALL_SPEED);

    // Speed grows by one per paddle hit up to twice the base, resets on serve
    always_ff @(posedge clk) begin
        if (rst) begin
            speed <= SPEED_INIT;
        end else if (bus.frame_tick && state == ST_PLAY) begin
            if (hit_left || hit_right) begin
                if (speed < SPEED_MAX) begin
                    speed <= SPW'(speed + SPW'(1));
                end
            end else if (miss_left || miss_right) begin
                speed <= SPEED_INIT;
            end
        end
    end
`else
    assign speed = SPEED_INIT;
`endif

    // Vertical resolution: bounce off top and bottom walls
    always_comb begin
        y_next  = y_e;
        dy_next = dy_down;
        if (!dy_down && (y_e < speed_y)) begin
            y_next  = '0;
            dy_next = 1'b1;
        end else if (dy_down && (YE'(y_e + speed_y) >= Y_MAX)) begin
            y_next  = Y_MAX;
            dy_next = 1'b0;
        end else if (dy_down) begin
            y_next  = YE'(y_e + speed_y);
        end else begin
            y_next  = YE'(y_e - speed_y);
        end
    end

    // Horizontal resolution: paddle hits take priority over misses
    always_comb begin
        overlap_1  = (YE'(y_e + BALL_SIDE_Y) > pad_1_e) && (y_e < YE'(pad_1_e + PADDLE_H_Y));
        overlap_2  = (YE'(y_e + BALL_SIDE_Y) > pad_2_e) && (y_e < YE'(pad_2_e + PADDLE_H_Y));
        hit_left   = !dx_right && (x_e >= FACE_LEFT) &&
                     (XE'(x_e - speed_x) <= FACE_LEFT) && overlap_1;
        hit_right  = dx_right && (x_e <= FACE_RIGHT) &&
                     (XE'(x_e + speed_x) >= FACE_RIGHT) && overlap_2;
        miss_left  = !dx_right && (x_e < speed_x);
        miss_right = dx_right && (XE'(x_e + speed_x) > X_MAX);
        x_step     = dx_right ? XE'(x_e + speed_x) : XE'(x_e - speed_x);
    end

    // Game state machine; every update happens on a frame tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_SERVE;
            ball_x       <= SERVE_X;
            ball_y       <= SERVE_Y;
            dx_right     <= 1'b1;
            dy_down      <= 1'b1;
            serve_cnt    <= '0;
            score_1      <= '0;
            score_2      <= '0;
            point_scored <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            point_scored <= 1'b0;
            if (bus.frame_tick) begin
                case (state)
                    ST_SERVE: begin
                        ball_x <= SERVE_X;
                        ball_y <= SERVE_Y;
                        if (serve_cnt_inc == SERVE_LAST) begin
                            serve_cnt <= '0;
                            state     <= ST_PLAY;
                        end else begin
                            serve_cnt <= serve_cnt_inc;
                        end
                    end
                    ST_PLAY: begin
                        ball_y  <= YW'(y_next);
                        dy_down <= dy_next;
                        if (hit_left) begin
                            ball_x   <= XW'(FACE_LEFT);
                            dx_right <= 1'b1;
                        end else if (hit_right) begin
                            ball_x   <= XW'(FACE_RIGHT);
                            dx_right <= 1'b0;
                        end else if (miss_left) begin
                            score_2      <= score_2_inc;
                            point_scored <= 1'b1;
                            ball_x       <= SERVE_X;
                            ball_y       <= SERVE_Y;
                            dx_right     <= 1'b0;
                            serve_cnt    <= '0;
                            if (score_2_inc == SCORE_WIN) begin
                                state     <= ST_GAME_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state     <= ST_SERVE;
                            end
                        end else if (miss_right) begin
                            score_1      <= score_1_inc;
                            point_scored <= 1'b1;
                            ball_x       <= SERVE_X;
                            ball_y       <= SERVE_Y;
                            dx_right     <= 1'b1;
                            serve_cnt    <= '0;
                            if (score_1_inc == SCORE_WIN) begin
                                state     <= ST_GAME_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state     <= ST_SERVE;
                            end
                        end else begin
                            ball_x <= XW'(x_step);
                        end
                    end
                    ST_GAME_OVER: begin
                        ball_x    <= SERVE_X;
                        ball_y    <= SERVE_Y;
                        game_over <= 1'b1;
                    end
                    default: begin
                        state <= ST_SERVE;
                    end
                endcase
            end
        end
    end

    assign bus.ball_pos_x   = ball_x;
    assign bus.ball_pos_y   = ball_y;
    assign bus.score_1      = score_1;
    assign bus.score_2      = score_2;
    assign bus.point_scored = point_scored;
    assign bus.game_over    = game_over;

endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
Upstream game-logic stage feeding the VGA graphics driver. It advances the ball once per video frame, bounces it off the top/bottom walls and both paddles, detects misses, keeps both scores, and runs a serve delay between points. Its ball_pos_x/ball_pos_y outputs drive the graphics driver's ball position inputs directly. Paddle positions come from the paddle controllers.

Parameters:
HEIGHT_COUNTER_SIZE, 9, Y position ports are HEIGHT_COUNTER_SIZE+1 bits wide.
WIDTH_COUNTER_SIZE, 10, X position ports are WIDTH_COUNTER_SIZE+1 bits wide.
SCREEN_WIDTH, 640, active pixels per line.
SCREEN_HEIGHT, 480, active lines.
PADDLE_1_X, 16, left paddle left edge.
PADDLE_2_X, 616, right paddle left edge.
PADDLE_WIDTH, 8, paddle width in pixels.
PADDLE_HEIGHT, 64, paddle height in pixels.
BALL_SIDE_SIZE, 8, ball side length in pixels.
INITIAL_BALL_X, 316, serve X position.
INITIAL_BALL_Y, 236, serve Y position.
BALL_SPEED, 2, pixels per frame on each axis.
SERVE_DELAY_FRAMES, 60, frames the ball is held at serve position.
WIN_SCORE, 7, score that ends the game.

Ports:
clk  in  1  pixel clock.
rst  in  1  synchronous, active-high reset.
frame_tick  in  1  one-cycle pulse per frame; all game updates occur only on this pulse.
paddle_1_pos  in  HEIGHT_COUNTER_SIZE+1  left paddle top Y.
paddle_2_pos  in  HEIGHT_COUNTER_SIZE+1  right paddle top Y.
ball_pos_x  out  WIDTH_COUNTER_SIZE+1  ball left X; registered.
ball_pos_y  out  HEIGHT_COUNTER_SIZE+1  ball top Y; registered.
score_1  out  4  left player score.
score_2  out  4  right player score.
point_scored  out  1  one-cycle pulse on the cycle after a miss is detected.
game_over  out  1  high once either score reaches WIN_SCORE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst. rst takes effect on the next clk edge and overrides frame_tick.
- Reset values, also applied when rst is asserted mid-game:
  - ball at (INITIAL_BALL_X, INITIAL_BALL_Y); scores 0; point_scored 0; game_over 0.
  - state SERVE; serve counter 0; dx = +1 (right); dy = +1 (down).
- State machine, evaluated only when frame_tick=1:
  - SERVE: hold the ball at serve position and increment the counter. When the counter reaches SERVE_DELAY_FRAMES, clear it and go to PLAY. The ball does not move on this transition tick.
  - PLAY: move the ball. X and Y are resolved independently on the same tick.
  - GAME_OVER: ball held at serve position, game_over=1. Only rst exits this state.
- Y axis, using the current ball_y:
  - Moving up with ball_y < BALL_SPEED: new y = 0, dy flips to down.
  - Moving down with ball_y + BALL_SPEED >= SCREEN_HEIGHT - BALL_SIDE_SIZE: new y = SCREEN_HEIGHT - BALL_SIDE_SIZE, dy flips to up.
  - Otherwise: y ± BALL_SPEED.
- X axis, using current positions:
  - Vertical overlap with paddle p means ball_y + BALL_SIDE_SIZE > paddle_p_pos AND ball_y < paddle_p_pos + PADDLE_HEIGHT.
  - Left paddle hit: dx left, ball_x >= PADDLE_1_X + PADDLE_WIDTH, ball_x - BALL_SPEED <= PADDLE_1_X + PADDLE_WIDTH, and overlap with paddle 1. New x = PADDLE_1_X + PADDLE_WIDTH, dx flips to right.
  - Right paddle hit: mirror of the left rule, against face PADDLE_2_X - BALL_SIDE_SIZE. New x = that face, dx flips to left.
  - Left miss: dx left and ball_x < BALL_SPEED. score_2 += 1.
  - Right miss: dx right and ball_x + BALL_SPEED > SCREEN_WIDTH - BALL_SIDE_SIZE. score_1 += 1.
  - Paddle hit has priority over the miss check.
  - Otherwise: x ± BALL_SPEED.
- On a miss:
  - point_scored pulses for exactly one clk.
  - Ball returns to serve position; state becomes SERVE with the counter cleared.
  - dx points toward the player who conceded the point; dy is kept.
  - If the incremented score equals WIN_SCORE, go to GAME_OVER instead. Scores never exceed WIN_SCORE.
- Timing and widths:
  - Outputs update on the clk edge where frame_tick=1, so latency is 1 cycle.
  - All arithmetic is unsigned and evaluated one bit wider than the port, so no wrap-around occurs.
- frame_tick high for more than one cycle advances the game once per high cycle. The upstream source guarantees one-cycle pulses.

Optional Feature:
SPEEDUP_EN.
- Defined: a per-axis speed register starts at BALL_SPEED. It increments by 1 on every paddle hit, saturating at 2*BALL_SPEED, and is restored to BALL_SPEED on each serve. All wall, paddle and miss rules use this register in place of BALL_SPEED.
- Undefined: speed is the constant BALL_SPEED and no speed register exists.

Test Plan:
- Reset, then 60 frame_ticks, then 1 more tick -> ball holds (316,236) through tick 60 (SERVE → PLAY); after tick 61 the ball is at (318,238); scores 0.
- PLAY, ball at y=1 moving up -> next tick y=0, dy down; following tick y=2.
- paddle_1_pos=200, ball (25,220) moving left -> next tick x=24, dx right; following tick x=26.
- paddle_1_pos=0, ball (1,300) moving left -> point_scored pulses for 1 clk; score_2=1; ball (316,236); SERVE; dx left.
- score_1=6, ball at x=631 moving right, no paddle overlap -> score_1=7, game_over=1, ball frozen over 10 further ticks; rst asserted -> all reset values next clk.
- SPEEDUP_EN defined, two consecutive paddle hits -> X step becomes 3, then 4; the next serve restores a step of 2.
